// File: rtl/pss_search_ctrl_if.sv
// Bundle of the signals between the PSS search controller, the PSS detector
// and the sample stream. The master side is the controller itself.
interface pss_search_ctrl_if #(
  parameter int MAX_MISSES = 3
);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  logic              enable_i;
  logic              s_axis_in_tvalid;
  logic [1:0]        N_id_2_i;
  logic              N_id_2_valid_i;
  logic [1:0]        mode_o;
  logic [1:0]        requested_N_id_2_o;
  logic              locked_o;
  logic [1:0]        N_id_2_o;
  logic              peak_o;
  logic [MISS_W-1:0] miss_cnt_o;
  logic [1:0]        state_o;

  modport master (
    input  enable_i, s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
    output mode_o, requested_N_id_2_o, locked_o, N_id_2_o, peak_o,
           miss_cnt_o, state_o
  );

  modport slave (
    output enable_i, s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
    input  mode_o, requested_N_id_2_o, locked_o, N_id_2_o, peak_o,
           miss_cnt_o, state_o
  );
endinterface

// File: rtl/pss_search_ctrl.sv
// PSS search controller: full search until a peak is found, then sleeps the
// detector until the next expected SSB, opens a window around it and tracks
// the locked N_id_2. Consecutive empty windows drop lock back to full search.
module pss_search_ctrl #(
  parameter int SSB_PERIOD  = 76800,
  parameter int WINDOW_HALF = 64,
  parameter int MAX_MISSES  = 3,
  parameter int CNT_DW      = 20
) (
  input logic              clk_i,
  input logic              reset_ni,
  pss_search_ctrl_if.master bus
);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WINDOW = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ALL = 2'd0;
  localparam logic [1:0] MODE_ONE = 2'd1;
  localparam logic [1:0] MODE_OFF = 2'd2;

  localparam logic [CNT_DW-1:0] WIN_OPEN   = CNT_DW'(SSB_PERIOD - WINDOW_HALF);
  localparam logic [CNT_DW-1:0] WIN_CLOSE  = CNT_DW'(SSB_PERIOD + WINDOW_HALF);
  // After a miss the counter is placed where it would be had the peak sat
  // exactly on the nominal grid, so the next window stays centred.
  localparam logic [CNT_DW-1:0] REALIGN    = CNT_DW'(WINDOW_HALF);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISSES);

  // Detector mode implied by each controller state.
  function automatic logic [1:0] mode_for(input state_t st);
    logic [1:0] m;
    case (st)
      ST_IDLE:   m = MODE_OFF;
      ST_SEARCH: m = MODE_ALL;
      ST_WAIT:   m = MODE_OFF;
      ST_WINDOW: m = MODE_ONE;
      default:   m = MODE_OFF;
    endcase
    return m;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_DW-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [MISS_W-1:0] miss_r, miss_s, miss_inc_s;
  logic [1:0]        id_r, id_s;
  logic [1:0]        mode_r;
  logic              locked_r;
  logic              peak_r, peak_s;
  logic              match_s;

  assign cnt_inc_s  = cnt_r + CNT_DW'(1);
  assign miss_inc_s = miss_r + MISS_W'(1);
  assign match_s    = bus.N_id_2_valid_i && (bus.N_id_2_i == id_r);

  // Next-state, counter, miss and lock-id decisions for the coming cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    miss_s  = miss_r;
    id_s    = id_r;
    peak_s  = 1'b0;
    if (!bus.enable_i) begin
      state_s = ST_IDLE;
      miss_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (bus.N_id_2_valid_i) begin
            id_s    = bus.N_id_2_i;
            cnt_s   = '0;
            miss_s  = '0;
            peak_s  = 1'b1;
            state_s = ST_WAIT;
          end else begin
            state_s = ST_SEARCH;
          end
        end
        ST_WAIT: begin
          if (bus.s_axis_in_tvalid) begin
            cnt_s = cnt_inc_s;
            if (cnt_inc_s == WIN_OPEN) begin
              state_s = ST_WINDOW;
            end else begin
              state_s = ST_WAIT;
            end
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_WINDOW: begin
          // A matching peak wins over both the strobe and the window close.
          if (match_s) begin
            cnt_s   = '0;
            miss_s  = '0;
            peak_s  = 1'b1;
            state_s = ST_WAIT;
          end else if (bus.s_axis_in_tvalid) begin
            if (cnt_inc_s == WIN_CLOSE) begin
              cnt_s = REALIGN;
              if (miss_inc_s == MISS_LIMIT) begin
                miss_s  = '0;
                state_s = ST_SEARCH;
              end else begin
                miss_s  = miss_inc_s;
                state_s = ST_WAIT;
              end
            end else begin
              cnt_s   = cnt_inc_s;
              state_s = ST_WINDOW;
            end
          end else begin
            state_s = ST_WINDOW;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; all outputs follow the decision one cycle later.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      miss_r   <= '0;
      id_r     <= 2'd0;
      mode_r   <= MODE_OFF;
      locked_r <= 1'b0;
      peak_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      miss_r   <= miss_s;
      id_r     <= id_s;
      mode_r   <= mode_for(state_s);
      locked_r <= (state_s == ST_WAIT) || (state_s == ST_WINDOW);
      peak_r   <= peak_s;
    end
  end

  assign bus.state_o            = state_r;
  assign bus.mode_o             = mode_r;
  assign bus.requested_N_id_2_o = id_r;
  assign bus.N_id_2_o           = id_r;
  assign bus.locked_o           = locked_r;
  assign bus.peak_o             = peak_r;
  assign bus.miss_cnt_o         = miss_r;
endmodule

// File: tb/tb_pss_search_ctrl.sv
// Directed bench for pss_search_ctrl with SSB_PERIOD=1000, WINDOW_HALF=10,
// MAX_MISSES=3 and a sample strobe on every cycle.
module tb_pss_search_ctrl;
  logic clk_i;
  logic reset_ni;
  int   vectors;
  int   miscompares;

  pss_search_ctrl_if #(.MAX_MISSES(3)) bus ();

  pss_search_ctrl #(
    .SSB_PERIOD (1000),
    .WINDOW_HALF(10),
    .MAX_MISSES (3),
    .CNT_DW     (20)
  ) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b1;
    #2 reset_ni = 1'b0;
    tick(2);
    vectors++; if (bus.state_o !== 2'd0) begin miscompares++; $display("FAIL rst_state got %0d want 0", bus.state_o); end
    vectors++; if (bus.mode_o !== 2'd2) begin miscompares++; $display("FAIL rst_mode got %0d want 2", bus.mode_o); end
    vectors++; if (bus.requested_N_id_2_o !== 2'd0) begin miscompares++; $display("FAIL rst_req got %0d want 0", bus.requested_N_id_2_o); end
    vectors++; if (bus.N_id_2_o !== 2'd0) begin miscompares++; $display("FAIL rst_id got %0d want 0", bus.N_id_2_o); end
    vectors++; if (bus.locked_o !== 1'b0) begin miscompares++; $display("FAIL rst_locked got %0d want 0", bus.locked_o); end
    vectors++; if (bus.peak_o !== 1'b0) begin miscompares++; $display("FAIL rst_peak got %0d want 0", bus.peak_o); end
    vectors++; if (bus.miss_cnt_o !== 2'd0) begin miscompares++; $display("FAIL rst_miss got %0d want 0", bus.miss_cnt_o); end
    reset_ni = 1'b1;
    tick(1);
    vectors++; if (bus.state_o !== 2'd0) begin miscompares++; $display("FAIL idle_hold got %0d want 0", bus.state_o); end
  endtask

  task automatic test_acquisition();
    bus.enable_i = 1'b1;
    tick(1);
    vectors++; if (bus.state_o !== 2'd1) begin miscompares++; $display("FAIL acq_search got %0d want 1", bus.state_o); end
    vectors++; if (bus.mode_o !== 2'd0) begin miscompares++; $display("FAIL acq_mode0 got %0d want 0", bus.mode_o); end
    vectors++; if (bus.locked_o !== 1'b0) begin miscompares++; $display("FAIL acq_unlocked got %0d want 0", bus.locked_o); end
    bus.N_id_2_i = 2'd2; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL acq_wait got %0d want 2", bus.state_o); end
    vectors++; if (bus.mode_o !== 2'd2) begin miscompares++; $display("FAIL acq_mode2 got %0d want 2", bus.mode_o); end
    vectors++; if (bus.locked_o !== 1'b1) begin miscompares++; $display("FAIL acq_locked got %0d want 1", bus.locked_o); end
    vectors++; if (bus.N_id_2_o !== 2'd2) begin miscompares++; $display("FAIL acq_id got %0d want 2", bus.N_id_2_o); end
    vectors++; if (bus.requested_N_id_2_o !== 2'd2) begin miscompares++; $display("FAIL acq_req got %0d want 2", bus.requested_N_id_2_o); end
    vectors++; if (bus.peak_o !== 1'b1) begin miscompares++; $display("FAIL acq_peak got %0d want 1", bus.peak_o); end
    tick(1);
    vectors++; if (bus.peak_o !== 1'b0) begin miscompares++; $display("FAIL acq_peak_single got %0d want 0", bus.peak_o); end
    tick(988);
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL acq_wait_989 got %0d want 2", bus.state_o); end
    tick(1);
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL acq_window_990 got %0d want 3", bus.state_o); end
    vectors++; if (bus.mode_o !== 2'd1) begin miscompares++; $display("FAIL acq_mode1 got %0d want 1", bus.mode_o); end
    vectors++; if (bus.requested_N_id_2_o !== 2'd2) begin miscompares++; $display("FAIL acq_req_win got %0d want 2", bus.requested_N_id_2_o); end
  endtask

  task automatic test_tracking();
    tick(13);
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL trk_window_1003 got %0d want 3", bus.state_o); end
    bus.N_id_2_i = 2'd2; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL trk_wait got %0d want 2", bus.state_o); end
    vectors++; if (bus.peak_o !== 1'b1) begin miscompares++; $display("FAIL trk_peak got %0d want 1", bus.peak_o); end
    vectors++; if (bus.miss_cnt_o !== 2'd0) begin miscompares++; $display("FAIL trk_miss got %0d want 0", bus.miss_cnt_o); end
    vectors++; if (bus.mode_o !== 2'd2) begin miscompares++; $display("FAIL trk_mode got %0d want 2", bus.mode_o); end
  endtask

  task automatic test_ignored();
    tick(500);
    bus.N_id_2_i = 2'd2; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL ign_wait_state got %0d want 2", bus.state_o); end
    vectors++; if (bus.peak_o !== 1'b0) begin miscompares++; $display("FAIL ign_wait_peak got %0d want 0", bus.peak_o); end
    tick(489);
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL ign_window_990 got %0d want 3", bus.state_o); end
    bus.N_id_2_i = 2'd1; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL ign_wrong_state got %0d want 3", bus.state_o); end
    vectors++; if (bus.peak_o !== 1'b0) begin miscompares++; $display("FAIL ign_wrong_peak got %0d want 0", bus.peak_o); end
    vectors++; if (bus.N_id_2_o !== 2'd2) begin miscompares++; $display("FAIL ign_wrong_id got %0d want 2", bus.N_id_2_o); end
    bus.N_id_2_i = 2'd2; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.peak_o !== 1'b1) begin miscompares++; $display("FAIL ign_accept_peak got %0d want 1", bus.peak_o); end
  endtask

  task automatic test_misses();
    tick(1009);
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL miss_window_1009 got %0d want 3", bus.state_o); end
    tick(1);
    vectors++; if (bus.miss_cnt_o !== 2'd1) begin miscompares++; $display("FAIL miss_first got %0d want 1", bus.miss_cnt_o); end
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL miss_first_state got %0d want 2", bus.state_o); end
    vectors++; if (bus.locked_o !== 1'b1) begin miscompares++; $display("FAIL miss_first_lock got %0d want 1", bus.locked_o); end
    tick(979);
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL miss_realign_989 got %0d want 2", bus.state_o); end
    tick(1);
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL miss_realign_990 got %0d want 3", bus.state_o); end
    tick(19);
    vectors++; if (bus.miss_cnt_o !== 2'd1) begin miscompares++; $display("FAIL miss_hold_1 got %0d want 1", bus.miss_cnt_o); end
    tick(1);
    vectors++; if (bus.miss_cnt_o !== 2'd2) begin miscompares++; $display("FAIL miss_second got %0d want 2", bus.miss_cnt_o); end
    tick(999);
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL miss_third_win got %0d want 3", bus.state_o); end
    tick(1);
    vectors++; if (bus.state_o !== 2'd1) begin miscompares++; $display("FAIL miss_loss_state got %0d want 1", bus.state_o); end
    vectors++; if (bus.mode_o !== 2'd0) begin miscompares++; $display("FAIL miss_loss_mode got %0d want 0", bus.mode_o); end
    vectors++; if (bus.locked_o !== 1'b0) begin miscompares++; $display("FAIL miss_loss_lock got %0d want 0", bus.locked_o); end
    vectors++; if (bus.miss_cnt_o !== 2'd0) begin miscompares++; $display("FAIL miss_loss_cnt got %0d want 0", bus.miss_cnt_o); end
  endtask

  task automatic test_simultaneous();
    bus.N_id_2_i = 2'd2; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL sim_reacq got %0d want 2", bus.state_o); end
    tick(1009);
    bus.N_id_2_i = 2'd2; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.peak_o !== 1'b1) begin miscompares++; $display("FAIL sim_peak got %0d want 1", bus.peak_o); end
    vectors++; if (bus.miss_cnt_o !== 2'd0) begin miscompares++; $display("FAIL sim_miss got %0d want 0", bus.miss_cnt_o); end
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL sim_state got %0d want 2", bus.state_o); end
    tick(989);
    vectors++; if (bus.state_o !== 2'd2) begin miscompares++; $display("FAIL sim_cnt0_989 got %0d want 2", bus.state_o); end
    tick(1);
    vectors++; if (bus.state_o !== 2'd3) begin miscompares++; $display("FAIL sim_cnt0_990 got %0d want 3", bus.state_o); end
  endtask

  task automatic test_enable_drop();
    bus.enable_i = 1'b0;
    tick(1);
    vectors++; if (bus.state_o !== 2'd0) begin miscompares++; $display("FAIL en_idle got %0d want 0", bus.state_o); end
    vectors++; if (bus.mode_o !== 2'd2) begin miscompares++; $display("FAIL en_mode got %0d want 2", bus.mode_o); end
    vectors++; if (bus.locked_o !== 1'b0) begin miscompares++; $display("FAIL en_lock got %0d want 0", bus.locked_o); end
    vectors++; if (bus.N_id_2_o !== 2'd2) begin miscompares++; $display("FAIL en_id_kept got %0d want 2", bus.N_id_2_o); end
    bus.enable_i = 1'b1; bus.N_id_2_i = 2'd1; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.state_o !== 2'd1) begin miscompares++; $display("FAIL en_search got %0d want 1", bus.state_o); end
    vectors++; if (bus.peak_o !== 1'b0) begin miscompares++; $display("FAIL en_idle_peak got %0d want 0", bus.peak_o); end
    vectors++; if (bus.locked_o !== 1'b0) begin miscompares++; $display("FAIL en_idle_lock got %0d want 0", bus.locked_o); end
  endtask

  task automatic test_reset_mid();
    bus.N_id_2_i = 2'd1; bus.N_id_2_valid_i = 1'b1;
    tick(1);
    bus.N_id_2_valid_i = 1'b0;
    vectors++; if (bus.N_id_2_o !== 2'd1) begin miscompares++; $display("FAIL rm_id got %0d want 1", bus.N_id_2_o); end
    tick(100);
    #2 reset_ni = 1'b0;
    #1;
    vectors++; if (bus.state_o !== 2'd0) begin miscompares++; $display("FAIL rm_state got %0d want 0", bus.state_o); end
    vectors++; if (bus.mode_o !== 2'd2) begin miscompares++; $display("FAIL rm_mode got %0d want 2", bus.mode_o); end
    vectors++; if (bus.requested_N_id_2_o !== 2'd0) begin miscompares++; $display("FAIL rm_req got %0d want 0", bus.requested_N_id_2_o); end
    vectors++; if (bus.N_id_2_o !== 2'd0) begin miscompares++; $display("FAIL rm_idout got %0d want 0", bus.N_id_2_o); end
    vectors++; if (bus.locked_o !== 1'b0) begin miscompares++; $display("FAIL rm_lock got %0d want 0", bus.locked_o); end
    vectors++; if (bus.peak_o !== 1'b0) begin miscompares++; $display("FAIL rm_peak got %0d want 0", bus.peak_o); end
    vectors++; if (bus.miss_cnt_o !== 2'd0) begin miscompares++; $display("FAIL rm_miss got %0d want 0", bus.miss_cnt_o); end
    bus.enable_i = 1'b0;
    reset_ni = 1'b1;
    tick(1);
    vectors++; if (bus.state_o !== 2'd0) begin miscompares++; $display("FAIL rm_after got %0d want 0", bus.state_o); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    bus.enable_i = 1'b0;
    bus.s_axis_in_tvalid = 1'b1;
    bus.N_id_2_i = 2'd0;
    bus.N_id_2_valid_i = 1'b0;
    test_reset();
    test_acquisition();
    test_tracking();
    test_ignored();
    test_misses();
    test_simultaneous();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
